// File: rtl/clk_div_reconfig_pkg.sv
// clk_div_reconfig_pkg
// Shared definitions for the divider reconfiguration controller:
//   - state_e          : sequencer states (IDLE, GATE, UPDATE, SETTLE)
//   - settle_cnt_width : width of the shared down-counter. It is wide enough to
//                        hold SettleMult * max_div - 1 without overflow.
package clk_div_reconfig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATE   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  function automatic int unsigned settle_cnt_width(input int unsigned div_width,
                                                   input int unsigned settle_mult);
    return div_width + 32'($clog2(settle_mult)) + 32'd1;
  endfunction

endpackage

// File: rtl/clk_div_reconfig_timer.sv
// clk_div_reconfig_timer
// Loadable down-counter with a zero flag. The sequencer shares it between the
// gate-delay phase and the settle phase.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset (count clears to 0)
//   load_i        : load load_val_i (takes priority over dec_i)
//   load_val_i    : value to load
//   dec_i         : decrement by one; the count holds at zero
//   zero_o        : count is zero
module clk_div_reconfig_timer #(
  parameter int unsigned Width = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q;
  logic [Width-1:0] count_d;

  // Next count: a load wins over a decrement, and a decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != {Width{1'b0}})) begin
      count_d = count_q - {{(Width-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register with a synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= {Width{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == {Width{1'b0}});

endmodule

// File: rtl/clk_div_reconfig_ctrl.sv
// clk_div_reconfig_ctrl
// Sequences a safe runtime change of an integer clock divider. The steps are:
// accept a new value, gate the divided clock, hand the value to the divider,
// wait SettleMult*new_div cycles, then re-enable the clock.
// Ports:
//   clk_i, rst_ni         : divider source clock, synchronous active-low reset
//   test_mode_en_i        : forces clk_en_o high and blocks new requests
//   cfg_div_i/valid/ready : request channel for a new division value
//   cfg_err_o             : one-cycle pulse, request rejected (0 or > MaxDiv)
//   done_o                : one-cycle pulse, reconfiguration finished (or no-op)
//   busy_o                : a sequence is in progress
//   div_o/valid/ready     : update handshake towards the divider
//   clk_en_o              : enable for the divided-clock gate
module clk_div_reconfig_ctrl
  import clk_div_reconfig_pkg::*;
#(
  parameter int unsigned DivWidth           = 8,
  parameter int unsigned MaxDiv             = 255,
  parameter int unsigned DefaultDiv         = 1,
  parameter int unsigned GateDelayCycles    = 2,
  parameter int unsigned SettleMult         = 2,
  parameter bit          EnableClockInReset = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                test_mode_en_i,
  input  logic [DivWidth-1:0] cfg_div_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  output logic                cfg_err_o,
  output logic                done_o,
  output logic                busy_o,
  output logic [DivWidth-1:0] div_o,
  output logic                div_valid_o,
  input  logic                div_ready_i,
  output logic                clk_en_o
);

  localparam int unsigned TW = settle_cnt_width(DivWidth, SettleMult);

  state_e              state_q, state_d;
  logic [DivWidth-1:0] div_q, div_d;
  logic [DivWidth-1:0] pend_q, pend_d;
  logic                div_valid_q, div_valid_d;
  logic                en_q, en_d;
  logic                err_q, err_d;
  logic                done_q, done_d;

  logic                tmr_load_s;
  logic                tmr_dec_s;
  logic [TW-1:0]       tmr_load_val_s;
  logic                tmr_zero_s;

  logic                handshake_s;
  logic                req_illegal_s;
  logic                req_same_s;
  logic [TW-1:0]       settle_load_s;

  assign cfg_ready_o   = (state_q == ST_IDLE) & ~test_mode_en_i;
  assign handshake_s   = cfg_valid_i & cfg_ready_o;
  assign req_illegal_s = (cfg_div_i == {DivWidth{1'b0}}) || (32'(cfg_div_i) > MaxDiv);
  assign req_same_s    = (cfg_div_i == div_q);
  // The counter runs from N-1 down to 0, which gives exactly N cycles in the phase.
  assign settle_load_s = (TW'(SettleMult) * {{(TW-DivWidth){1'b0}}, div_q}) - TW'(1'b1);

  // Sequencer next-state and output decisions.
  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    pend_d         = pend_q;
    div_valid_d    = div_valid_q;
    en_d           = en_q;
    err_d          = 1'b0;
    done_d         = 1'b0;
    tmr_load_s     = 1'b0;
    tmr_load_val_s = {TW{1'b0}};
    tmr_dec_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (handshake_s) begin
          if (req_illegal_s) begin
            err_d = 1'b1;
          end else if (req_same_s) begin
            done_d = 1'b1;
          end else begin
            pend_d         = cfg_div_i;
            en_d           = 1'b0;
            state_d        = ST_GATE;
            tmr_load_s     = 1'b1;
            tmr_load_val_s = TW'(GateDelayCycles - 32'd1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GATE: begin
        en_d = 1'b0;
        if (tmr_zero_s) begin
          div_d       = pend_q;
          div_valid_d = 1'b1;
          state_d     = ST_UPDATE;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      ST_UPDATE: begin
        // The sequencer waits indefinitely for the divider. No timeout is applied.
        if (div_ready_i) begin
          div_valid_d    = 1'b0;
          state_d        = ST_SETTLE;
          tmr_load_s     = 1'b1;
          tmr_load_val_s = settle_load_s;
        end else begin
          div_valid_d = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero_s) begin
          en_d    = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        div_valid_d = 1'b0;
        en_d        = 1'b1;
      end
    endcase
  end

  // Sequencer registers. A reset aborts any sequence in progress at once.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      div_q       <= DivWidth'(DefaultDiv);
      pend_q      <= DivWidth'(DefaultDiv);
      div_valid_q <= 1'b0;
      en_q        <= EnableClockInReset;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      pend_q      <= pend_d;
      div_valid_q <= div_valid_d;
      en_q        <= en_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  clk_div_reconfig_timer #(
    .Width(TW)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_load_val_s),
    .dec_i      (tmr_dec_s),
    .zero_o     (tmr_zero_s)
  );

  assign busy_o      = (state_q != ST_IDLE);
  assign div_o       = div_q;
  assign div_valid_o = div_valid_q;
  assign cfg_err_o   = err_q;
  assign done_o      = done_q;
  // Test mode overrides the gate combinationally so that scan clocks are never blocked.
  assign clk_en_o    = en_q | test_mode_en_i;

endmodule

// File: tb/tb_clk_div_reconfig_ctrl.sv
module tb_clk_div_reconfig_ctrl;

  localparam int DW   = 8;
  localparam int MAXD = 100;
  localparam int DEFD = 1;
  localparam int GD   = 2;
  localparam int SM   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tm;
  logic [DW-1:0] cfg_div;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          cfg_err;
  logic          done;
  logic          busy;
  logic [DW-1:0] div;
  logic          div_valid;
  logic          div_ready;
  logic          clk_en;

  always #5 clk = ~clk;

  clk_div_reconfig_ctrl #(
    .DivWidth(DW), .MaxDiv(MAXD), .DefaultDiv(DEFD),
    .GateDelayCycles(GD), .SettleMult(SM), .EnableClockInReset(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .test_mode_en_i(tm),
    .cfg_div_i(cfg_div), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_err_o(cfg_err), .done_o(done), .busy_o(busy),
    .div_o(div), .div_valid_o(div_valid), .div_ready_i(div_ready),
    .clk_en_o(clk_en)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: the remaining cycles of each phase after an acceptance.
  bit model_on = 1'b0;
  bit m_busy, m_upd, m_err, m_done;
  int m_div, m_pend, m_gate_left, m_settle_left;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_on = 1'b1;
      m_busy = 0; m_upd = 0; m_err = 0; m_done = 0;
      m_div = DEFD; m_pend = DEFD; m_gate_left = 0; m_settle_left = 0;
    end else begin
      m_err = 0; m_done = 0;
      if (!m_busy) begin
        if (cfg_valid && !tm) begin
          if (int'(cfg_div) == 0 || int'(cfg_div) > MAXD) m_err = 1;
          else if (int'(cfg_div) == m_div) m_done = 1;
          else begin
            m_busy = 1; m_pend = int'(cfg_div); m_gate_left = GD;
          end
        end
      end else if (m_gate_left > 0) begin
        m_gate_left--;
        if (m_gate_left == 0) begin
          m_div = m_pend; m_upd = 1;
        end
      end else if (m_upd) begin
        if (div_ready) begin
          m_upd = 0; m_settle_left = SM * m_div;
        end
      end else begin
        m_settle_left--;
        if (m_settle_left == 0) begin
          m_busy = 0; m_done = 1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
  endtask

  // Compare process: all outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        chk("cfg_ready", int'(cfg_ready), int'(!m_busy && !tm));
        chk("busy", int'(busy), int'(m_busy));
        chk("div", int'(div), m_div);
        chk("div_valid", int'(div_valid), int'(m_upd));
        chk("clk_en", int'(clk_en), int'(!m_busy || tm));
        chk("cfg_err", int'(cfg_err), int'(m_err));
        chk("done", int'(done), int'(m_done));
      end
    end
  end

  task automatic wait_done(input int limit, output int n, output int vcyc);
    n = 0; vcyc = 0;
    while (n < limit) begin
      step();
      n++;
      if (div_valid) vcyc++;
      if (done) break;
    end
  endtask

  int n, v, k;

  initial begin
    rst_n = 1'b0; tm = 1'b0; cfg_div = '0; cfg_valid = 1'b0; div_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    // Values after reset
    chk("rst_div", int'(div), 1);
    chk("rst_clk_en", int'(clk_en), 1);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_div_valid", int'(div_valid), 0);

    // Legal change 1 -> 4 with the divider always ready
    cfg_div = 8'd4; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("gate_clk_en_low", int'(clk_en), 0);
    wait_done(200, n, v);
    chk("lat_1to4", n, 11);
    chk("valid_cycles_1to4", v, 1);
    chk("done_1to4", int'(done), 1);
    chk("clk_en_at_done", int'(clk_en), 1);
    chk("div_after_1to4", int'(div), 4);

    // Illegal requests, then a request for the value already in use
    cfg_valid = 1'b1; cfg_div = 8'd0;
    step();
    chk("err_zero", int'(cfg_err), 1);
    cfg_div = 8'(MAXD + 1);
    step();
    chk("err_over", int'(cfg_err), 1);
    chk("div_kept", int'(div), 4);
    cfg_div = 8'd4;
    step();
    chk("same_done", int'(done), 1);
    chk("same_not_busy", int'(busy), 0);
    cfg_valid = 1'b0;
    step();

    // Back-pressure: the divider holds off for 20 cycles and a second request stalls
    div_ready = 1'b0; cfg_div = 8'd7; cfg_valid = 1'b1;
    step();
    cfg_div = 8'd9;
    k = 0;
    while (!div_valid && k < 10) begin step(); k++; end
    chk("gate_len", k, GD);
    repeat (20) step();
    chk("bp_valid", int'(div_valid), 1);
    chk("bp_div", int'(div), 7);
    chk("bp_clk_en", int'(clk_en), 0);
    chk("bp_ready", int'(cfg_ready), 0);
    div_ready = 1'b1;
    wait_done(200, n, v);
    chk("bp_lat", n, 1 + SM * 7);
    step();
    cfg_valid = 1'b0;
    chk("stalled_req_taken", int'(busy), 1);
    wait_done(200, n, v);
    chk("lat_7to9", n, GD + 1 + SM * 9);
    chk("div_after_7to9", int'(div), 9);

    // Reset in the middle of SETTLE
    cfg_div = 8'd10; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    repeat (GD + 1 + 3) step();
    chk("in_settle", int'(busy), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_div", int'(div), DEFD);
    chk("mrst_clk_en", int'(clk_en), 1);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_done", int'(done), 0);
    step();
    chk("mrst_no_done", int'(done), 0);

    // Test mode raised during GATE
    cfg_div = 8'd3; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    tm = 1'b1;
    #1;
    chk("tm_clk_en", int'(clk_en), 1);
    chk("tm_ready", int'(cfg_ready), 0);
    wait_done(200, n, v);
    chk("tm_lat", n, GD + 1 + SM * 3 - 1);
    chk("tm_done", int'(done), 1);
    tm = 1'b0;
    step();

    // Random traffic checked by the model
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      tm        = ($urandom_range(0, 15) == 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      div_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) cfg_div = 8'($urandom_range(0, 255));
      else cfg_div = 8'($urandom_range(0, 12));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
